sap_param_core: RTL and testbench
=================================

Name: sap_param_core

Overview:
Parametrised next-generation SAP processor core. It integrates the program counter, MAR, IR, accumulator, flags, ALU, RAM and output register behind one multi-cycle control FSM, instead of a gated clock with fixed 8/4-bit widths. It adds carry/zero flags, conditional jumps, store, immediate load, an explicit halt state, and a debounced-edge program-load mode. It replaces the fixed SAP top as the team's configurable core.

Parameters:
DATA_W, 8, data and instruction word width; constraint DATA_W >= ADDR_W+4
ADDR_W, 4, RAM address width; RAM depth is 2**ADDR_W words

Ports:
clock  input  1  system clock, all state on rising edge
clear  input  1  synchronous active-high reset
WR  input  1  load-mode write request, level; its rising edge writes
prog_run  input  1  1 = execute, 0 = program-load mode
ram_dip  input  DATA_W  load-mode write data
mar_dip  input  ADDR_W  load-mode write address
SAP_OUT  output  DATA_W  output register
out_valid  output  1  one-cycle pulse when OUT executes
halted  output  1  high while in HALT state
carry  output  1  C flag
zero  output  1  Z flag
pc_dbg  output  ADDR_W  current PC

Behaviour:
- Reset: clear=1 at a rising edge sets PC=0, MAR=0, IR=0, A=0, C=0, Z=0, SAP_OUT=0, out_valid=0, wr_q=0, state=FETCH_A. RAM contents are not reset. clear has priority over everything.
- Instruction format: opcode = IR[DATA_W-1:DATA_W-4], operand = IR[ADDR_W-1:0]. Bits between opcode and operand are ignored.
- Opcodes: 0 NOP, 1 LDA, 2 ADD, 3 SUB, 4 STA, 5 LDI, 6 JMP, 7 JC, 8 JZ, 9 AND, A OR, B XOR, E OUT, F HLT. C and D execute as NOP.
- RAM read is asynchronous (RAM[MAR]); RAM write is synchronous.
- State FETCH_A: MAR<=PC, go to FETCH_I.
- State FETCH_I: IR<=RAM[MAR], PC<=PC+1 modulo 2**ADDR_W (wraps from max to 0), go to EXEC1.
- State EXEC1, by opcode:
  - NOP: go to FETCH_A.
  - LDI: A<=zero-extended operand; update Z; go to FETCH_A.
  - JMP: PC<=operand.
  - JC: PC<=operand only if C=1.
  - JZ: PC<=operand only if Z=1.
  - OUT: SAP_OUT<=A; out_valid=1 for exactly this cycle.
  - HLT: go to HALT.
  - LDA/ADD/SUB/AND/OR/XOR/STA: MAR<=operand; go to EXEC2.
  - All other EXEC1 cases return to FETCH_A.
- State EXEC2 (M = RAM[MAR]):
  - LDA: A<=M.
  - ADD: {C,A}<=A+M, computed DATA_W+1 bits wide.
  - SUB: A<=A-M mod 2**DATA_W; C=1 iff A>=M (no borrow).
  - AND/OR/XOR: A<=A op M; C unchanged.
  - STA: RAM[MAR]<=A; flags unchanged.
  - Z<=(new A==0) whenever A is written.
  - Go to FETCH_A.
- Latency: NOP/LDI/jumps/OUT/HLT take 3 cycles; memory-operand instructions take 4.
- HALT: all registers hold and halted=1. Only clear or prog_run=0 leaves it.
- Load mode: prog_run=0 at any edge forces state LOAD, aborting any in-flight instruction. PC, A, flags and SAP_OUT hold.
  - wr_q<=WR every cycle.
  - WR=1 with wr_q=0 writes RAM[mar_dip]<=ram_dip, one write per WR assertion regardless of hold length.
  - WR is ignored while prog_run=1.
- Return to run: prog_run 0->1 goes LOAD to FETCH_A with PC unchanged. Software restarts by pulsing clear.
- out_valid is low in all cycles other than OUT's EXEC1.

Decomposition:
- Package sap_pkg: opcode localparams (OP_NOP..OP_HLT), state enum (FETCH_A, FETCH_I, EXEC1, EXEC2, HALT, LOAD), and the opcode field width of 4.
- Natural sub-module: sap_param_ram (ADDR_W x DATA_W, async read, sync write port muxed between the STA path and the load path). FSM, datapath and ALU stay in the core.

Test Plan:
1. Basic arithmetic.
   - Stimulus: load RAM 0:0x19, 1:0x2A, 2:0xE0, 3:0xF0, 9:0x05, A:0x03; clear; prog_run=1.
   - Required: out_valid pulses in run cycle 11 with SAP_OUT=0x08; halted=1 from cycle 14 onward; C=0, Z=0.
2. ADD carry and JC.
   - Stimulus: A=0xF0 plus M=0x20, followed by JC 5.
   - Required: A=0x10, C=1, Z=0; next fetch comes from address 5. Repeat with 0x10+0x20: C=0, jump not taken, PC continues sequentially.
3. SUB equal and JZ.
   - Stimulus: 0x07-0x07, followed by JZ 0xC.
   - Required: A=0x00, Z=1, C=1; PC=0xC. Also 0x03-0x05 gives A=0xFE, C=0, Z=0.
4. STA and PC wrap.
   - Stimulus: LDI 9 then STA 0xF at the start of the program; a NOP placed at 0xF.
   - Required: RAM[0xF] reads back 0x09. After executing address 0xF, pc_dbg wraps to 0.
5. Load-mode WR handling.
   - Stimulus: hold WR high for 5 cycles with mar_dip=3, ram_dip=0xAB.
   - Required: exactly one write, RAM[3]=0xAB. WR pulses while prog_run=1 leave RAM unchanged.
6. Aborts.
   - Stimulus: drop prog_run during EXEC2 of STA; separately assert clear during EXEC2 of ADD.
   - Required: prog_run drop gives state LOAD with no RAM write and A held. clear drives all outputs to reset values on the next edge and fetch restarts from address 0.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared definitions for the parametrised SAP core: opcode encodings and
// the control FSM state set.
package sap_pkg;

    localparam int OPC_W = 4;

    typedef logic [OPC_W-1:0] opcode_t;

    localparam opcode_t OP_NOP = 4'h0;
    localparam opcode_t OP_LDA = 4'h1;
    localparam opcode_t OP_ADD = 4'h2;
    localparam opcode_t OP_SUB = 4'h3;
    localparam opcode_t OP_STA = 4'h4;
    localparam opcode_t OP_LDI = 4'h5;
    localparam opcode_t OP_JMP = 4'h6;
    localparam opcode_t OP_JC  = 4'h7;
    localparam opcode_t OP_JZ  = 4'h8;
    localparam opcode_t OP_AND = 4'h9;
    localparam opcode_t OP_OR  = 4'hA;
    localparam opcode_t OP_XOR = 4'hB;
    localparam opcode_t OP_OUT = 4'hE;
    localparam opcode_t OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        FETCH_A,
        FETCH_I,
        EXEC1,
        EXEC2,
        HALT,
        LOAD
    } state_t;

endpackage

// File: rtl/sap_param_ram.sv
// Program/data RAM: asynchronous read, one synchronous write port shared
// between the program-load path and the STA execution path.
module sap_param_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              sta_we,
    input  logic [ADDR_W-1:0] sta_addr,
    input  logic [DATA_W-1:0] sta_data,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    // The two writers are mutually exclusive: loads happen only with the core stopped.
    assign we    = sta_we | ld_we;
    assign waddr = ld_we ? ld_addr : sta_addr;
    assign wdata = ld_we ? ld_data : sta_data;

    // NOTE: the memory array has no reset; clearing it would turn the RAM into flops.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sap_param_core.sv
// Multi-cycle SAP core: PC, MAR, IR, accumulator, C/Z flags, ALU and output
// register sequenced by one FSM, with a program-load mode for the RAM.
module sap_param_core
    import sap_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              WR,
    input  logic              prog_run,
    input  logic [DATA_W-1:0] ram_dip,
    input  logic [ADDR_W-1:0] mar_dip,
    output logic [DATA_W-1:0] SAP_OUT,
    output logic              out_valid,
    output logic              halted,
    output logic              carry,
    output logic              zero,
    output logic [ADDR_W-1:0] pc_dbg
);

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [ADDR_W-1:0] mar, mar_n;
    opcode_t           ir_op, ir_op_n;
    logic [ADDR_W-1:0] ir_opnd, ir_opnd_n;
    logic [DATA_W-1:0] a, a_n;
    logic [DATA_W-1:0] sap_out_q, sap_out_n;
    logic              c, c_n;
    logic              z, z_n;
    logic              out_valid_q, out_valid_n;
    logic              wr_q;
    logic              sta_we, ld_we;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W:0]   sum_w, diff_w;
    logic [DATA_W-1:0] opnd_ext;

    // The IR keeps only the opcode and operand fields; the bits between are don't-care.
    assign sum_w    = {1'b0, a} + {1'b0, ram_rdata};
    assign diff_w   = {1'b0, a} - {1'b0, ram_rdata};
    assign opnd_ext = {{(DATA_W-ADDR_W){1'b0}}, ir_opnd};
    assign ld_we    = ~prog_run & WR & ~wr_q & ~clear;

    sap_param_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk     (clock),
        .sta_we  (sta_we & ~clear),
        .sta_addr(mar),
        .sta_data(a),
        .ld_we   (ld_we),
        .ld_addr (mar_dip),
        .ld_data (ram_dip),
        .rd_addr (mar),
        .rd_data (ram_rdata)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n     = state;
        pc_n        = pc;
        mar_n       = mar;
        ir_op_n     = ir_op;
        ir_opnd_n   = ir_opnd;
        a_n         = a;
        c_n         = c;
        z_n         = z;
        sap_out_n   = sap_out_q;
        out_valid_n = 1'b0;
        sta_we      = 1'b0;

        if (!prog_run) begin
            state_n = LOAD;
        end else begin
            case (state)
                FETCH_A: begin
                    mar_n   = pc;
                    state_n = FETCH_I;
                end
                FETCH_I: begin
                    ir_op_n   = ram_rdata[DATA_W-1 -: OPC_W];
                    ir_opnd_n = ram_rdata[ADDR_W-1:0];
                    pc_n      = pc + ADDR_W'(1);
                    state_n   = EXEC1;
                end
                EXEC1: begin
                    state_n = FETCH_A;
                    case (ir_op)
                        OP_LDI: begin
                            a_n = opnd_ext;
                            z_n = (opnd_ext == '0);
                        end
                        OP_JMP: pc_n = ir_opnd;
                        OP_JC:  if (c) pc_n = ir_opnd;
                        OP_JZ:  if (z) pc_n = ir_opnd;
                        OP_OUT: begin
                            sap_out_n   = a;
                            out_valid_n = 1'b1;
                        end
                        OP_HLT: state_n = HALT;
                        OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_STA: begin
                            mar_n   = ir_opnd;
                            state_n = EXEC2;
                        end
                        default: ;
                    endcase
                end
                EXEC2: begin
                    state_n = FETCH_A;
                    case (ir_op)
                        OP_LDA: a_n = ram_rdata;
                        OP_ADD: {c_n, a_n} = sum_w;
                        OP_SUB: begin
                            a_n = diff_w[DATA_W-1:0];
                            c_n = ~diff_w[DATA_W];
                        end
                        OP_AND: a_n = a & ram_rdata;
                        OP_OR:  a_n = a | ram_rdata;
                        OP_XOR: a_n = a ^ ram_rdata;
                        OP_STA: sta_we = 1'b1;
                        default: ;
                    endcase
                    if (ir_op != OP_STA) begin
                        z_n = (a_n == '0);
                    end
                end
                HALT:    state_n = HALT;
                LOAD:    state_n = FETCH_A;
                default: state_n = FETCH_A;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (clear) begin
            state <= FETCH_A;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            pc          <= '0;
            mar         <= '0;
            ir_op       <= '0;
            ir_opnd     <= '0;
            a           <= '0;
            c           <= 1'b0;
            z           <= 1'b0;
            sap_out_q   <= '0;
            out_valid_q <= 1'b0;
            wr_q        <= 1'b0;
        end else begin
            pc          <= pc_n;
            mar         <= mar_n;
            ir_op       <= ir_op_n;
            ir_opnd     <= ir_opnd_n;
            a           <= a_n;
            c           <= c_n;
            z           <= z_n;
            sap_out_q   <= sap_out_n;
            out_valid_q <= out_valid_n;
            wr_q        <= WR;
        end
    end

    assign SAP_OUT   = sap_out_q;
    assign out_valid = out_valid_q;
    assign halted    = (state == HALT);
    assign carry     = c;
    assign zero      = z;
    assign pc_dbg    = pc;

endmodule

// File: tb/tb_sap_param_core.sv
// Directed bench for sap_param_core: table of whole programs with expected
// end state, plus hand sequences for timing, load mode and aborts.
module tb_sap_param_core;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int NV     = 8;

    logic              clock = 1'b0;
    logic              clear;
    logic              WR;
    logic              prog_run;
    logic [DATA_W-1:0] ram_dip;
    logic [ADDR_W-1:0] mar_dip;
    logic [DATA_W-1:0] SAP_OUT;
    logic              out_valid;
    logic              halted;
    logic              carry;
    logic              zero;
    logic [ADDR_W-1:0] pc_dbg;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [15:0][7:0] prog;
        int               cycles;
        logic [7:0]       exp_out;
        logic             exp_c;
        logic             exp_z;
        logic             exp_halt;
        logic [3:0]       exp_pc;
        logic [3:0]       chk_addr;
        logic [7:0]       chk_data;
    } vec_t;

    vec_t v [NV];

    sap_param_core #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clock    (clock),
        .clear    (clear),
        .WR       (WR),
        .prog_run (prog_run),
        .ram_dip  (ram_dip),
        .mar_dip  (mar_dip),
        .SAP_OUT  (SAP_OUT),
        .out_valid(out_valid),
        .halted   (halted),
        .carry    (carry),
        .zero     (zero),
        .pc_dbg   (pc_dbg)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_word(input logic [3:0] addr, input logic [7:0] data);
        prog_run = 1'b0;
        mar_dip  = addr;
        ram_dip  = data;
        WR       = 1'b1;
        tick();
        WR = 1'b0;
        tick();
    endtask

    task automatic load_prog(input logic [15:0][7:0] p);
        for (int k = 0; k < 16; k++) begin
            load_word(4'(k), p[k]);
        end
    endtask

    task automatic restart();
        prog_run = 1'b1;
        clear    = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic set_exp(input int i, input int cyc, input logic [7:0] o, input logic c,
                           input logic z, input logic h, input logic [3:0] pc,
                           input logic [3:0] ca, input logic [7:0] cd);
        v[i].cycles   = cyc;
        v[i].exp_out  = o;
        v[i].exp_c    = c;
        v[i].exp_z    = z;
        v[i].exp_halt = h;
        v[i].exp_pc   = pc;
        v[i].chk_addr = ca;
        v[i].chk_data = cd;
    endtask

    initial begin
        for (int i = 0; i < NV; i++) v[i].prog = '0;
        // basic: LDA 9, ADD A, OUT, HLT -> 5+3
        v[0].prog[0] = 8'h19; v[0].prog[1] = 8'h2A; v[0].prog[2] = 8'hE0; v[0].prog[3] = 8'hF0;
        v[0].prog[9] = 8'h05; v[0].prog[10] = 8'h03;
        set_exp(0, 14, 8'h08, 1'b0, 1'b0, 1'b1, 4'h4, 4'h9, 8'h05);
        // F0+20 carries, JC 5 taken to OUT/HLT at 5/6
        v[1].prog[0] = 8'h18; v[1].prog[1] = 8'h29; v[1].prog[2] = 8'h75; v[1].prog[3] = 8'hE0;
        v[1].prog[4] = 8'hF0; v[1].prog[5] = 8'hE0; v[1].prog[6] = 8'hF0; v[1].prog[7] = 8'h61;
        v[1].prog[8] = 8'hF0; v[1].prog[9] = 8'h20;
        set_exp(1, 17, 8'h10, 1'b1, 1'b0, 1'b1, 4'h7, 4'h8, 8'hF0);
        // 10+20 no carry, JC falls through to OUT/HLT at 3/4
        v[2].prog = v[1].prog; v[2].prog[8] = 8'h10;
        set_exp(2, 17, 8'h30, 1'b0, 1'b0, 1'b1, 4'h5, 4'h8, 8'h10);
        // 07-07 = 0, JZ C taken to OUT/HLT at C/D
        v[3].prog[0] = 8'h18; v[3].prog[1] = 8'h39; v[3].prog[2] = 8'h8C; v[3].prog[3] = 8'hE0;
        v[3].prog[4] = 8'hF0; v[3].prog[12] = 8'hE0; v[3].prog[13] = 8'hF0;
        v[3].prog[8] = 8'h07; v[3].prog[9] = 8'h07;
        set_exp(3, 17, 8'h00, 1'b1, 1'b1, 1'b1, 4'hE, 4'h9, 8'h07);
        // 03-05 borrows: FE, C=0, JZ not taken
        v[4].prog = v[3].prog; v[4].prog[8] = 8'h03; v[4].prog[9] = 8'h05;
        set_exp(4, 17, 8'hFE, 1'b0, 1'b0, 1'b1, 4'h5, 4'h9, 8'h05);
        // 3C & 0F | 50 ^ FF = A3
        v[5].prog[0] = 8'h18; v[5].prog[1] = 8'h99; v[5].prog[2] = 8'hAA; v[5].prog[3] = 8'hBB;
        v[5].prog[4] = 8'hE0; v[5].prog[5] = 8'hF0; v[5].prog[8] = 8'h3C; v[5].prog[9] = 8'h0F;
        v[5].prog[10] = 8'h50; v[5].prog[11] = 8'hFF;
        set_exp(5, 22, 8'hA3, 1'b0, 1'b0, 1'b1, 4'h6, 4'hB, 8'hFF);
        // LDI 9, STA F, JMP E; NOPs at E/F, PC wraps to 0 in cycle 15
        v[6].prog[0] = 8'h59; v[6].prog[1] = 8'h4F; v[6].prog[2] = 8'h6E;
        set_exp(6, 16, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 4'hF, 8'h09);
        // LDI 0 sets Z; opcodes C and D behave as NOP
        v[6+1].prog[0] = 8'h50; v[7].prog[1] = 8'hC0; v[7].prog[2] = 8'hD0;
        v[7].prog[3] = 8'hE0; v[7].prog[4] = 8'hF0;
        set_exp(7, 15, 8'h00, 1'b0, 1'b1, 1'b1, 4'h5, 4'h0, 8'h50);

        clear    = 1'b1;
        WR       = 1'b0;
        prog_run = 1'b0;
        ram_dip  = '0;
        mar_dip  = '0;

        // reset state
        tick();
        check("rst.sap_out", SAP_OUT, 8'h00);
        check("rst.out_valid", out_valid, 1'b0);
        check("rst.halted", halted, 1'b0);
        check("rst.carry", carry, 1'b0);
        check("rst.zero", zero, 1'b0);
        check("rst.pc", pc_dbg, 4'h0);
        clear = 1'b0;
        tick();

        // table of whole programs
        for (int i = 0; i < NV; i++) begin
            load_prog(v[i].prog);
            restart();
            repeat (v[i].cycles) tick();
            check($sformatf("vec%0d.sap_out", i), SAP_OUT, v[i].exp_out);
            check($sformatf("vec%0d.carry", i), carry, v[i].exp_c);
            check($sformatf("vec%0d.zero", i), zero, v[i].exp_z);
            check($sformatf("vec%0d.halted", i), halted, v[i].exp_halt);
            check($sformatf("vec%0d.pc", i), pc_dbg, v[i].exp_pc);
            check($sformatf("vec%0d.ram", i), dut.u_ram.mem[v[i].chk_addr], v[i].chk_data);
        end

        // cycle-exact out_valid / halted timing of the basic program
        load_prog(v[0].prog);
        restart();
        for (int cyc = 1; cyc <= 16; cyc++) begin
            tick();
            check($sformatf("timing.out_valid@%0d", cyc), out_valid, (cyc == 11));
            check($sformatf("timing.halted@%0d", cyc), halted, (cyc >= 14));
            if (cyc == 10) check("timing.sap_out@10", SAP_OUT, 8'h00);
            if (cyc == 11) check("timing.sap_out@11", SAP_OUT, 8'h08);
        end

        // load mode: one write per WR assertion, WR ignored while running
        load_word(4'h0, 8'hF0);
        load_word(4'h3, 8'h00);
        mar_dip = 4'h3;
        ram_dip = 8'hAB;
        WR      = 1'b1;
        tick();
        ram_dip = 8'hCD;
        repeat (4) tick();
        WR = 1'b0;
        tick();
        check("load.hold_one_write", dut.u_ram.mem[3], 8'hAB);
        mar_dip = 4'h4;
        ram_dip = 8'h77;
        WR      = 1'b1;
        tick();
        WR = 1'b0;
        tick();
        check("load.second_edge", dut.u_ram.mem[4], 8'h77);
        restart();
        repeat (3) tick();
        check("load.run_halted", halted, 1'b1);
        mar_dip = 4'h3;
        ram_dip = 8'h55;
        for (int k = 0; k < 3; k++) begin
            WR = 1'b1;
            tick();
            WR = 1'b0;
            tick();
        end
        check("load.wr_ignored_run", dut.u_ram.mem[3], 8'hAB);

        // prog_run drop in EXEC2 of STA: no write, PC and A held
        v[0].prog = '0;
        v[0].prog[0] = 8'h55; v[0].prog[1] = 8'h47; v[0].prog[2] = 8'hE0; v[0].prog[3] = 8'hF0;
        v[0].prog[7] = 8'h33;
        load_prog(v[0].prog);
        restart();
        repeat (6) tick();
        prog_run = 1'b0;
        repeat (3) tick();
        check("abort_sta.ram", dut.u_ram.mem[7], 8'h33);
        check("abort_sta.pc", pc_dbg, 4'h2);
        check("abort_sta.halted", halted, 1'b0);
        prog_run = 1'b1;
        repeat (4) tick();
        check("abort_sta.out_valid", out_valid, 1'b1);
        check("abort_sta.a_held", SAP_OUT, 8'h05);

        // clear in EXEC2 of ADD: everything back to reset, fetch from 0
        load_prog(v[1].prog);
        restart();
        repeat (17) tick();
        check("abort_clr.pre_halt", halted, 1'b1);
        prog_run = 1'b0;
        tick();
        prog_run = 1'b1;
        tick();
        repeat (6) tick();
        check("abort_clr.pre_pc", pc_dbg, 4'h2);
        check("abort_clr.pre_out", SAP_OUT, 8'h10);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("abort_clr.sap_out", SAP_OUT, 8'h00);
        check("abort_clr.carry", carry, 1'b0);
        check("abort_clr.zero", zero, 1'b0);
        check("abort_clr.pc", pc_dbg, 4'h0);
        check("abort_clr.halted", halted, 1'b0);
        check("abort_clr.out_valid", out_valid, 1'b0);
        repeat (11) tick();
        check("abort_clr.jc_pc", pc_dbg, 4'h5);
        repeat (3) tick();
        check("abort_clr.out_valid2", out_valid, 1'b1);
        check("abort_clr.sap_out2", SAP_OUT, 8'h10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
